// File: rtl/cgra_run_ctrl.sv
// cgra_run_ctrl: start/done handshake and shared instruction-address sequencer for the PE array
module cgra_run_ctrl #(
  parameter int IADDR_WIDTH  = 8,
  parameter int ITER_WIDTH   = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                   Clk,
  input  logic                   Resetn,
  input  logic                   Computation_Start,
  output logic                   Computation_Done,
  input  logic [IADDR_WIDTH-1:0] Inst_Num,
  input  logic [ITER_WIDTH-1:0]  Iter_Num,
  input  logic                   Stall,
  output logic [IADDR_WIDTH-1:0] Inst_Addr,
  output logic                   Inst_Valid,
  output logic [ITER_WIDTH-1:0]  Iter_Count,
  output logic                   Iter_Last,
  output logic                   PE_Array_Busy
);
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_t;
  state_t                 state;
  logic [IADDR_WIDTH-1:0] inst_num_q;
  logic [ITER_WIDTH-1:0]  iter_num_q;
  logic [DW-1:0]          drain_cnt;
  logic                   addr_end;
  assign addr_end         = Inst_Addr == inst_num_q - IADDR_WIDTH'(1);
  assign Iter_Last        = state == RUN && Iter_Count == iter_num_q - ITER_WIDTH'(1);
  assign Inst_Valid       = state == RUN && !Stall;
  assign Computation_Done = state == DONE;
  assign PE_Array_Busy    = state == INIT || state == RUN || state == DRAIN;
  always_ff @(posedge Clk or negedge Resetn)
    if (!Resetn) begin
      state      <= IDLE;
      inst_num_q <= '0;
      iter_num_q <= '0;
      drain_cnt  <= '0;
      Inst_Addr  <= '0;
      Iter_Count <= '0;
    end else
      case (state)
        IDLE: if (Computation_Start) state <= INIT;
        INIT: begin
          inst_num_q <= Inst_Num;
          iter_num_q <= Iter_Num;
          Inst_Addr  <= '0;
          Iter_Count <= '0;
          drain_cnt  <= '0;
          state      <= (Inst_Num == '0 || Iter_Num == '0) ? DONE : RUN;
        end
        RUN: if (!Stall) begin
          Inst_Addr <= addr_end ? '0 : Inst_Addr + IADDR_WIDTH'(1);
          if (addr_end && Iter_Last) state <= DRAIN_CYCLES == 0 ? DONE : DRAIN;
          else if (addr_end) Iter_Count <= Iter_Count + ITER_WIDTH'(1);
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_cnt == DW'(DRAIN_CYCLES - 1)) state <= DONE;
        end
        DONE: if (!Computation_Start) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule
